// File: rtl/sig_sweep_if.sv
// sig_sweep_if: control/config/status bundle between the sweep sequencer
// and its control source.
//   master : control source (drives start/abort/cfg_*, reads status)
//   slave  : sig_sweep_ctrl (reads start/abort/cfg_*, drives status)
interface sig_sweep_if #(
  parameter int PHASE_W = 16,
  parameter int DWELL_W = 16
);
  logic               start;
  logic               abort;
  logic               cfg_continuous;
  logic [PHASE_W-1:0] cfg_start_inc;
  logic [PHASE_W-1:0] cfg_stop_inc;
  logic [PHASE_W-1:0] cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [PHASE_W-1:0] phase_inc;
  logic               phase_upd;
  logic               out_en;
  logic               busy;
  logic               done;
  logic               cfg_err;
  logic [15:0]        pass_count;

  modport master (
    output start, abort, cfg_continuous, cfg_start_inc, cfg_stop_inc, cfg_step, cfg_dwell,
    input  phase_inc, phase_upd, out_en, busy, done, cfg_err, pass_count
  );
  modport slave (
    input  start, abort, cfg_continuous, cfg_start_inc, cfg_stop_inc, cfg_step, cfg_dwell,
    output phase_inc, phase_upd, out_en, busy, done, cfg_err, pass_count
  );
endinterface

// File: rtl/sig_sweep_ctrl.sv
// sig_sweep_ctrl: frequency-sweep sequencer feeding the phase increment of
// the sin/cos generator. Waits for a settled clock-wizard lock, then steps
// the phase increment from start to stop in step-sized points, each lasting
// cfg_dwell+1 cycles; single pass or continuous.
// Ports:
//   clk, reset  : generator clock, synchronous active-high reset
//   dcm_locked  : clock wizard lock (synchronous to clk)
//   bus (slave) : start/abort/cfg_* in; phase_inc/phase_upd/out_en/busy/
//                 done/cfg_err/pass_count out (all registered except busy,
//                 which is decoded straight from the state register)
module sig_sweep_ctrl #(
  parameter int PHASE_W     = 16,
  parameter int DWELL_W     = 16,
  parameter int LOCK_SETTLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dcm_locked,
  sig_sweep_if.slave bus
);
  localparam int LW = (LOCK_SETTLE < 2) ? 1 : $clog2(LOCK_SETTLE + 1);

  typedef enum logic [1:0] {IDLE, WAIT_LOCK, DWELL, DONE} state_t;

  state_t             state, state_d;
  logic [LW-1:0]      lcnt, lcnt_d;
  logic [DWELL_W-1:0] dcnt, dcnt_d;
  logic [PHASE_W-1:0] cur, cur_d;
  logic [PHASE_W-1:0] ph, ph_d;
  logic               upd, upd_d, oen, oen_d, done_q, done_d, err, err_d;
  logic [15:0]        pc, pc_d;
  // config captured at start acceptance
  logic [PHASE_W-1:0] start_q, start_qd, stop_q, stop_qd, step_q, step_qd;
  logic [DWELL_W-1:0] dwell_q, dwell_qd;
  logic               cont_q, cont_qd;
  // one extra bit so cur+step can never wrap past stop
  logic [PHASE_W:0]   nxt;

  assign nxt = {1'b0, cur} + {1'b0, step_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      lcnt    <= '0;
      dcnt    <= '0;
      cur     <= '0;
      ph      <= '0;
      upd     <= 1'b0;
      oen     <= 1'b0;
      done_q  <= 1'b0;
      err     <= 1'b0;
      pc      <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
    end else begin
      state   <= state_d;
      lcnt    <= lcnt_d;
      dcnt    <= dcnt_d;
      cur     <= cur_d;
      ph      <= ph_d;
      upd     <= upd_d;
      oen     <= oen_d;
      done_q  <= done_d;
      err     <= err_d;
      pc      <= pc_d;
      start_q <= start_qd;
      stop_q  <= stop_qd;
      step_q  <= step_qd;
      dwell_q <= dwell_qd;
      cont_q  <= cont_qd;
    end
  end

  always_comb begin
    state_d  = state;
    lcnt_d   = lcnt;
    dcnt_d   = dcnt;
    cur_d    = cur;
    ph_d     = ph;
    upd_d    = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    pc_d     = pc;
    start_qd = start_q;
    stop_qd  = stop_q;
    step_qd  = step_q;
    dwell_qd = dwell_q;
    cont_qd  = cont_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.cfg_start_inc <= bus.cfg_stop_inc) begin
            start_qd = bus.cfg_start_inc;
            stop_qd  = bus.cfg_stop_inc;
            step_qd  = bus.cfg_step;
            dwell_qd = bus.cfg_dwell;
            cont_qd  = bus.cfg_continuous;
            cur_d    = bus.cfg_start_inc;
            pc_d     = '0;
            lcnt_d   = '0;
            state_d  = WAIT_LOCK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT_LOCK: begin
        // phase_inc keeps the point interrupted by lock loss (0 on first entry)
        if (!dcm_locked) begin
          lcnt_d = '0;
        end else if (lcnt == LW'(LOCK_SETTLE - 1)) begin
          lcnt_d  = '0;
          dcnt_d  = '0;
          ph_d    = cur;
          upd_d   = 1'b1;
          state_d = DWELL;
        end else begin
          lcnt_d = lcnt + 1'b1;
        end
      end
      DWELL: begin
        if (!dcm_locked) begin
          // keep cur; the point restarts with a full dwell after relock
          lcnt_d  = '0;
          state_d = WAIT_LOCK;
        end else if (dcnt == dwell_q) begin
          dcnt_d = '0;
          if (step_q != '0 && nxt <= {1'b0, stop_q}) begin
            cur_d = nxt[PHASE_W-1:0];
            ph_d  = nxt[PHASE_W-1:0];
            upd_d = 1'b1;
          end else begin
            pc_d = pc + 16'd1;
            if (cont_q) begin
              cur_d = start_q;
              ph_d  = start_q;
              upd_d = 1'b1;
            end else begin
              done_d  = 1'b1;
              state_d = DONE;
            end
          end
        end else begin
          dcnt_d = dcnt + 1'b1;
        end
      end
      DONE: begin
        ph_d    = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // abort outranks lock loss and dwell completion; pass_count is kept
    if (bus.abort && state != IDLE) begin
      state_d = IDLE;
      ph_d    = '0;
      upd_d   = 1'b0;
      done_d  = 1'b0;
      pc_d    = pc;
    end
    oen_d = (state_d == DWELL);
  end

  assign bus.phase_inc  = ph;
  assign bus.phase_upd  = upd;
  assign bus.out_en     = oen;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
  assign bus.cfg_err    = err;
  assign bus.pass_count = pc;
endmodule

// File: tb/tb_sig_sweep_ctrl.sv
// Bench for sig_sweep_ctrl: directed scenarios plus randomized sweeps, each
// compared cycle by cycle against an expected-output trace built from the
// list of sweep points.
module tb_sig_sweep_ctrl;
  localparam int LS = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dcm_locked = 1'b1;
  always #5 clk = ~clk;

  sig_sweep_if #(.PHASE_W(16), .DWELL_W(16)) bus ();

  sig_sweep_ctrl #(.PHASE_W(16), .DWELL_W(16), .LOCK_SETTLE(LS)) dut (
    .clk(clk), .reset(reset), .dcm_locked(dcm_locked), .bus(bus)
  );

  typedef struct {
    logic [15:0] ph, pc;
    logic        upd, oen, busy, done;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int ph, input bit upd, input bit oen, input bit busy,
                      input bit done, input int pc);
    exp_t e;
    e.ph = 16'(ph); e.pc = 16'(pc);
    e.upd = upd; e.oen = oen; e.busy = busy; e.done = done;
    q.push_back(e);
  endtask

  // Expected trace: lock_n settle cycles, then npass passes over the point
  // list (dw+1 cycles each), then DONE and IDLE for a single-pass sweep.
  task automatic gen_sweep(input int s, input int e, input int st, input int dw,
                           input int lock_n, input int lock_ph, input int npass,
                           input bit cont, input int pc0);
    int pts[$];
    int p, pc;
    for (int i = 0; i < lock_n; i++) push(lock_ph, 0, 0, 1, 0, pc0);
    p = s;
    forever begin
      pts.push_back(p);
      if (st == 0 || p + st > e) break;
      p += st;
    end
    pc = pc0;
    for (int n = 0; n < npass; n++) begin
      foreach (pts[i])
        for (int k = 0; k <= dw; k++) push(pts[i], k == 0, 1, 1, 0, pc);
      pc = (pc + 1) % 65536;
    end
    if (!cont) begin
      push(pts[pts.size()-1], 0, 0, 1, 1, pc);
      push(0, 0, 0, 0, 0, pc);
    end
  endtask

  task automatic scramble();
    bus.cfg_start_inc  = 16'($urandom);
    bus.cfg_stop_inc   = 16'($urandom);
    bus.cfg_step       = 16'($urandom);
    bus.cfg_dwell      = 16'($urandom);
    bus.cfg_continuous = 1'($urandom);
  endtask

  task automatic launch(input int s, input int e, input int st, input int dw, input bit cont);
    bus.cfg_start_inc  = 16'(s);
    bus.cfg_stop_inc   = 16'(e);
    bus.cfg_step       = 16'(st);
    bus.cfg_dwell      = 16'(dw);
    bus.cfg_continuous = cont;
    bus.start          = 1'b1;
  endtask

  task automatic check_out(input exp_t e);
    chk("phase_inc", bus.phase_inc, e.ph);
    chk("phase_upd", 16'(bus.phase_upd), 16'(e.upd));
    chk("out_en", 16'(bus.out_en), 16'(e.oen));
    chk("busy", 16'(bus.busy), 16'(e.busy));
    chk("done", 16'(bus.done), 16'(e.done));
    chk("pass_count", bus.pass_count, e.pc);
    chk("cfg_err", 16'(bus.cfg_err), 16'h0);
  endtask

  // Walks the expected trace; config is scrambled every cycle and start is
  // randomly re-pulsed while busy, neither of which may disturb the sweep.
  task automatic check_trace();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      step();
      bus.start = 1'b0;
      scramble();
      check_out(e);
      if (e.busy && $urandom_range(0, 7) == 0) bus.start = 1'b1;
    end
    bus.start = 1'b0;
  endtask

  task automatic wait_upd(input int ph, input string tag);
    int n = 0;
    while (!(bus.phase_upd === 1'b1 && bus.phase_inc === 16'(ph)) && n < 200) begin
      step();
      bus.start = 1'b0;
      n++;
    end
    chk(tag, 16'(n < 200), 16'h1);
  endtask

  task automatic check_idle(input string tag, input int pc);
    exp_t e;
    e.ph = '0; e.pc = 16'(pc); e.upd = 0; e.oen = 0; e.busy = 0; e.done = 0;
    chk(tag, 16'(bus.busy), 16'h0);
    check_out(e);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    scramble();
    step(); step();
    check_idle("reset_state", 0);
    reset = 1'b0;

    // basic sweep: 0x10..0x40 step 0x10, dwell 2; first pulse 5 edges after start
    launch(16'h10, 16'h40, 16'h10, 2, 0);
    gen_sweep(16'h10, 16'h40, 16'h10, 2, LS, 0, 1, 0, 0);
    check_trace();

    // overflow guard: 0xFFF0 + 0x20 must not wrap
    launch(16'hFFF0, 16'hFFFF, 16'h20, 1, 0);
    gen_sweep(16'hFFF0, 16'hFFFF, 16'h20, 1, LS, 0, 1, 0, 0);
    check_trace();

    // step of 0 gives a one-point pass
    launch(16'h1234, 16'h2000, 0, 0, 0);
    gen_sweep(16'h1234, 16'h2000, 0, 0, LS, 0, 1, 0, 0);
    check_trace();

    // continuous 5,6,7 dwell 0, two passes then the third begins with pc=2
    launch(5, 7, 1, 0, 1);
    gen_sweep(5, 7, 1, 0, LS, 0, 2, 1, 0);
    push(5, 1, 1, 1, 0, 2);
    check_trace();
    // reset mid-DWELL clears everything including pass_count
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("reset_mid_dwell", 0);

    // config error
    launch(16'h50, 16'h40, 16'h10, 0, 0);
    step();
    bus.start = 1'b0;
    chk("cfg_err_pulse", 16'(bus.cfg_err), 16'h1);
    chk("cfg_err_busy", 16'(bus.busy), 16'h0);
    step();
    chk("cfg_err_width", 16'(bus.cfg_err), 16'h0);
    chk("cfg_err_busy2", 16'(bus.busy), 16'h0);

    // lock loss during point 0x20, relock, 0x20 repeats with full dwell
    launch(16'h10, 16'h40, 16'h10, 2, 0);
    wait_upd(16'h20, "lock_wait_timeout");
    dcm_locked = 1'b0;
    step();
    dcm_locked = 1'b1;
    chk("lockloss_out_en", 16'(bus.out_en), 16'h0);
    chk("lockloss_busy", 16'(bus.busy), 16'h1);
    chk("lockloss_phase", bus.phase_inc, 16'h20);
    gen_sweep(16'h20, 16'h40, 16'h10, 2, LS - 1, 16'h20, 1, 0, 0);
    check_trace();

    // abort on the dwell-completion cycle of point 0x10
    launch(16'h10, 16'h40, 16'h10, 2, 0);
    wait_upd(16'h10, "abort_wait_timeout");
    step(); step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check_idle("abort_idle", 0);
    step();
    check_idle("abort_no_done", 0);

    // randomized single-pass sweeps, some near the top of the range
    for (int it = 0; it < 10; it++) begin
      int s, e, st, dw;
      if (it % 3 == 2) begin
        s  = $urandom_range(16'hFF00, 16'hFFFF);
        e  = 16'hFFFF;
        st = $urandom_range(0, 16'h80);
      end else begin
        s  = $urandom_range(0, 16'hF000);
        e  = s + $urandom_range(0, 150);
        st = $urandom_range(0, 40);
      end
      dw = $urandom_range(0, 3);
      launch(s, e, st, dw, 0);
      gen_sweep(s, e, st, dw, LS, 0, 1, 0, 0);
      check_trace();
    end

    // randomized continuous sweeps: two passes, then abort keeps pass_count
    for (int it = 0; it < 4; it++) begin
      int s, e, st, dw;
      s  = $urandom_range(0, 16'hF000);
      e  = s + $urandom_range(0, 60);
      st = $urandom_range(1, 20);
      dw = $urandom_range(0, 2);
      launch(s, e, st, dw, 1);
      gen_sweep(s, e, st, dw, LS, 0, 2, 1, 0);
      push(s, 1, 1, 1, 0, 2);
      check_trace();
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      check_idle("cont_abort", 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sig_sweep_ctrl.md
Name: sig_sweep_ctrl

Overview:
- Sequencer that drives the phase-increment (frequency) input of the sin/cos signal generator.
- Performs programmable frequency sweeps, single-shot or continuous.
- Holds off and gates generator output until the clock wizard reports a stable lock.
- Sits between the control/config source and the generator, in the generator's clock domain (clk_out3 of the clock wizard).

Parameters:
- PHASE_W, 16: width of phase increment and all frequency config fields.
- DWELL_W, 16: width of the dwell counter and cfg_dwell.
- LOCK_SETTLE, 16: consecutive cycles dcm_locked must be high before the sweep runs (>=1).

Ports:
- clk  in  1  generator clock.
- reset  in  1  synchronous, active-high reset.
- dcm_locked  in  1  clock wizard lock status (already synchronous to clk).
- start  in  1  request sweep; sampled only in IDLE.
- abort  in  1  stop any sweep immediately.
- cfg_continuous  in  1  1 = restart sweep from cfg_start_inc after each pass; 0 = single pass.
- cfg_start_inc  in  PHASE_W  first sweep point.
- cfg_stop_inc  in  PHASE_W  upper bound of the sweep.
- cfg_step  in  PHASE_W  increment between points.
- cfg_dwell  in  DWELL_W  cycles per point minus 1.
- phase_inc  out  PHASE_W  registered phase increment to the generator.
- phase_upd  out  1  one-cycle pulse on the first cycle of each sweep point.
- out_en  out  1  generator output qualifier.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on natural completion of a single-pass sweep.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- pass_count  out  16  completed passes since start; wraps at 0xFFFF->0.

Behaviour:
- Reset: all outputs, state and counters go to 0/IDLE on the next clk edge. Reset overrides all other inputs, including mid-sweep.
- States: IDLE, WAIT_LOCK, DWELL, DONE.
- Config latching: all cfg_* inputs are captured when start is accepted. Later changes to cfg_* have no effect until the next start.

IDLE:
- start=1 with cfg_start_inc <= cfg_stop_inc: latch config, clear pass_count, go to WAIT_LOCK.
- start=1 with cfg_start_inc > cfg_stop_inc: pulse cfg_err, stay in IDLE.
- phase_inc=0, out_en=0.

WAIT_LOCK:
- Lock counter increments on each cycle dcm_locked=1 and clears on each cycle dcm_locked=0.
- When the counter reaches LOCK_SETTLE, go to DWELL.
- out_en=0 throughout. phase_inc holds the current point (0 on first entry).

DWELL:
- First cycle of each point: phase_inc = current point, phase_upd=1, out_en=1.
- A point lasts exactly cfg_dwell+1 cycles (cfg_dwell=0 gives 1 cycle per point).
- End of point: compute next = cur + step at PHASE_W+1 bits; no wrap is permitted.
  - If step != 0 and next <= stop: cur = next, start a new point.
  - Otherwise (pass complete): pass_count++.
    - Continuous mode: cur = start, new point.
    - Single-pass mode: go to DONE.
- cfg_step=0 means the pass is a single point at start.
- Lock loss: dcm_locked=0 in DWELL goes to WAIT_LOCK next cycle with out_en=0. The current point is kept. After relock, that point restarts with a full dwell and phase_upd=1.

DONE:
- One cycle: done=1, out_en=0. Next state is IDLE, with phase_inc cleared to 0 on entry to IDLE.

abort:
- In any non-IDLE state, go to IDLE next cycle.
- No done pulse. pass_count holds its value.
- Priority (highest first): reset, abort, lock loss, dwell completion.

Latency:
- Start accepted at cycle T with dcm_locked held high: first phase_upd at T+1+LOCK_SETTLE.
- Output pulses (done, phase_upd, cfg_err) are registered and exactly one cycle wide.

Test Plan:
- Basic sweep (LOCK_SETTLE=4, locked=1, start=0x0010, stop=0x0040, step=0x0010, dwell=2, single pass): phase_upd pulses with phase_inc 0x10, 0x20, 0x30, 0x40, spaced 3 cycles apart. The first pulse is at T+5. done pulses once, 3 cycles after the 0x40 pulse, then busy=0 and phase_inc=0.
- Overflow guard (PHASE_W=16, start=0xFFF0, stop=0xFFFF, step=0x0020): single point 0xFFF0, then done. No wrap to 0x0010.
- Continuous mode (start=5, stop=7, step=1, dwell=0): phase_inc sequence 5,6,7,5,6,7 on consecutive cycles. pass_count reads 1 after the first 7 point completes and 2 after the second. done is never pulsed.
- Lock loss and config error:
  - Drop dcm_locked for 1 cycle during point 0x20: out_en falls next cycle.
  - After 4 cycles relocked, 0x20 repeats with a full dwell and phase_upd=1.
  - A separate start with start=0x50, stop=0x40 gives a cfg_err pulse and busy stays 0.
- Abort and reset:
  - abort asserted the same cycle as dwell completion: IDLE next cycle, no done, phase_inc=0.
  - reset mid-DWELL: all outputs 0 after the edge.
  - start asserted while busy: ignored, and the sweep continues unchanged.
